// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, baud divisors and frame limits
// shared by the UART transmitter and receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // clk cycles per bit at 100 MHz
   localparam int DIV_9600   = 10417;
   localparam int DIV_57600  = 1736;
   localparam int DIV_115200 = 868;

   localparam int DBIT_MIN = 5;
   localparam int DBIT_MAX = 8;
   localparam int SB_MIN   = 1;
   localparam int SB_MAX   = 2;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: free-running divider with sync clear;
// tick marks the last cycle of each DIV-cycle period.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int DIV = DIV_115200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int W = cnt_w(DIV);

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: pops bytes from a show-ahead FIFO and sends them
// as start + DBIT data (LSB first) + SB_BITS stop, no parity.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_BITS = 1,
   parameter int CLK_DIV = DIV_115200
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tx_en,
   input  logic            fifo_empty,
   input  logic [DBIT-1:0] fifo_data,
   output logic            fifo_rd,
   output logic            tx,
   output logic            tx_busy
);

   localparam int BW = cnt_w(DBIT);
   localparam int SW = cnt_w(SB_BITS);

   state_t          state, state_n;
   logic [DBIT-1:0] shreg, shreg_n;
   logic [BW-1:0]   bit_cnt, bit_cnt_n;
   logic [SW-1:0]   stop_cnt, stop_cnt_n;
   logic            tx_n, busy_n;
   logic            clr, tick;

   uart_baud_cnt #(
      .DIV(CLK_DIV)
   ) u_baud (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= '0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         bit_cnt  <= bit_cnt_n;
         stop_cnt <= stop_cnt_n;
         tx       <= tx_n;
         tx_busy  <= busy_n;
      end
   end

   // tx_n is the line level for the next cycle, so tx stays a pure flop
   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      bit_cnt_n  = bit_cnt;
      stop_cnt_n = stop_cnt;
      tx_n       = tx;
      busy_n     = tx_busy;
      fifo_rd    = 1'b0;
      clr        = 1'b0;
      unique case (state)
         IDLE: begin
            clr  = 1'b1;
            tx_n = 1'b1;
            if (tx_en && !fifo_empty) begin
               fifo_rd    = 1'b1;
               shreg_n    = fifo_data;
               bit_cnt_n  = '0;
               stop_cnt_n = '0;
               tx_n       = 1'b0;
               busy_n     = 1'b1;
               state_n    = START;
            end
         end
         START: begin
            if (tick) begin
               tx_n    = shreg[0];
               state_n = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               shreg_n = shreg >> 1;
               if (bit_cnt == BW'(DBIT - 1)) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
                  tx_n      = shreg[1];
               end
            end
         end
         STOP: begin
            tx_n = 1'b1;
            if (tick) begin
               if (stop_cnt == SW'(SB_BITS - 1)) begin
                  busy_n  = 1'b0;
                  state_n = IDLE;
               end else begin
                  stop_cnt_n = stop_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; FIFO model feeds uart_tx and
// each popped byte's expected frame is compared cycle by cycle.
module tb_uart_tx;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_en;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data = '0;
   logic       fifo_rd, tx, tx_busy;

   logic       f2_en, f2_empty;
   logic [6:0] f2_data;
   logic       f2_rd, tx2, busy2;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   logic [7:0] drop;

   int         cyc_cnt = 0;
   int         n_pops = 0, n_frames = 0, n_aborts = 0;
   int         last_pop = 0, gap = 0, mon_cyc = 0;
   logic       mon_act = 1'b0, idle_chk = 1'b0;
   logic [7:0] cur;
   logic [63:0] txv, bsv;

   uart_tx #(
      .DBIT(8), .SB_BITS(1), .CLK_DIV(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_en     (tx_en),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_rd   (fifo_rd),
      .tx        (tx),
      .tx_busy   (tx_busy)
   );

   uart_tx #(
      .DBIT(7), .SB_BITS(2), .CLK_DIV(3)
   ) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_en     (f2_en),
      .fifo_empty(f2_empty),
      .fifo_data (f2_data),
      .fifo_rd   (f2_rd),
      .tx        (tx2),
      .tx_busy   (busy2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic logic [63:0] frame8(input logic [7:0] b);
      logic [63:0] v;
      int i;
      v = '0;
      for (int k = 0; k < 40; k++) begin
         i = k / 4;
         if (i == 0)      v[k] = 1'b0;
         else if (i <= 8) v[k] = b[i-1];
         else             v[k] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [63:0] frame7(input logic [6:0] b);
      logic [63:0] v;
      int i;
      v = '0;
      for (int k = 0; k < 30; k++) begin
         i = k / 3;
         if (i == 0)      v[k] = 1'b0;
         else if (i <= 7) v[k] = b[i-1];
         else             v[k] = 1'b1;
      end
      return v;
   endfunction

   // show-ahead FIFO model; flags update on the clock edge
   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (fifo_rd && fq.size() != 0) drop = fq.pop_front();
      fifo_empty <= (fq.size() == 0);
      fifo_data  <= (fq.size() != 0) ? fq[0] : 8'h00;
   end

   always @(negedge clk) begin
      if (idle_chk) begin
         chk("gap_tx", tx, 1);
         chk("gap_busy", tx_busy, 0);
         idle_chk = 1'b0;
      end
      if (mon_act) begin
         if (!rst_n) begin
            mon_act = 1'b0;
            n_aborts++;
         end else begin
            txv[mon_cyc] = tx;
            bsv[mon_cyc] = tx_busy;
            mon_cyc++;
            if (mon_cyc == 40) begin
               chk($sformatf("frame_%02h", cur), txv, frame8(cur));
               chk($sformatf("busy_%02h", cur), bsv, 64'hFF_FFFF_FFFF);
               mon_act = 1'b0;
               idle_chk = 1'b1;
               n_frames++;
            end
         end
      end
      if (fifo_rd) begin
         chk("rd_nonempty", fifo_empty, 0);
         chk("rd_single", mon_act, 0);
         if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
         else cur = exp_q.pop_front();
         mon_act = 1'b1;
         mon_cyc = 0;
         txv = '0;
         bsv = '0;
         n_pops++;
         gap = cyc_cnt - last_pop;
         last_pop = cyc_cnt;
      end
   end

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
   endtask

   task automatic wait_frames(input int n);
      int b = 0;
      while (n_frames < n && b < 2000) begin
         @(posedge clk);
         b++;
      end
      if (n_frames < n) chk("frame_timeout", n_frames, n);
   endtask

   task automatic wait_pops(input int n);
      int b = 0;
      while (n_pops < n && b < 2000) begin
         @(posedge clk);
         b++;
      end
      if (n_pops < n) chk("pop_timeout", n_pops, n);
   endtask

   initial begin
      int bad_tx, bad_rd, bad_bs, p0, f0, b, extra;
      logic [63:0] v2, b2;
      logic seen;
      rst_n = 1'b0;
      tx_en = 1'b0;
      f2_en = 1'b0;
      f2_empty = 1'b1;
      f2_data = '0;

      // reset and idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_rd", fifo_rd, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_state", dut.state, IDLE);
      rst_n = 1'b1;
      bad_tx = 0; bad_rd = 0; bad_bs = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) bad_tx++;
         if (fifo_rd !== 1'b0) bad_rd++;
         if (tx_busy !== 1'b0) bad_bs++;
      end
      chk("idle_tx_bad", bad_tx, 0);
      chk("idle_rd_bad", bad_rd, 0);
      chk("idle_busy_bad", bad_bs, 0);

      // single byte
      @(posedge clk); #1;
      tx_en = 1'b1;
      push(8'hA5);
      wait_frames(1);
      chk("single_pops", n_pops, 1);

      // back-to-back
      @(posedge clk); #1;
      push(8'h00);
      push(8'hFF);
      wait_frames(3);
      chk("b2b_pops", n_pops, 3);
      chk("b2b_gap", gap, 41);

      // tx_en gating
      @(posedge clk); #1;
      p0 = n_pops;
      f0 = n_frames;
      push(8'h3C);
      push(8'h55);
      wait_pops(p0 + 1);
      repeat (16) @(posedge clk);
      #1;
      tx_en = 1'b0;
      wait_frames(f0 + 1);
      repeat (10) @(posedge clk);
      #1;
      chk("gate_hold", n_pops, p0 + 1);
      chk("gate_rd_low", fifo_rd, 0);
      tx_en = 1'b1;
      @(negedge clk);
      chk("gate_pop", fifo_rd, 1);
      chk("gate_idle_tx", tx, 1);
      wait_frames(f0 + 2);

      // mid-frame reset during bit 5
      @(posedge clk); #1;
      p0 = n_pops;
      f0 = n_frames;
      push(8'h96);
      push(8'h5A);
      wait_pops(p0 + 1);
      repeat (26) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mrst_tx", tx, 1);
      chk("mrst_busy", tx_busy, 0);
      chk("mrst_state", dut.state, IDLE);
      chk("mrst_repop", fifo_rd, 1);
      wait_frames(f0 + 1);
      chk("mrst_aborts", n_aborts, 1);
      chk("mrst_pops", n_pops, p0 + 2);

      // DBIT=7, SB_BITS=2, CLK_DIV=3
      @(posedge clk); #1;
      f2_data = 7'h41;
      f2_empty = 1'b0;
      f2_en = 1'b1;
      b = 0;
      seen = 1'b0;
      while (!seen && b < 200) begin
         @(negedge clk);
         seen = f2_rd;
         b++;
      end
      chk("p_pop_seen", seen, 1);
      @(posedge clk); #1;
      f2_empty = 1'b1;
      f2_en = 1'b0;
      v2 = '0;
      b2 = '0;
      extra = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         v2[k] = tx2;
         b2[k] = busy2;
         if (f2_rd) extra++;
      end
      chk("p_frame_41", v2, frame7(7'h41));
      chk("p_busy", b2, 64'h3FFF_FFFF);
      chk("p_extra_rd", extra, 0);
      @(negedge clk);
      chk("p_end_tx", tx2, 1);
      chk("p_end_busy", busy2, 0);

      repeat (5) @(posedge clk);
      chk("sb_empty", exp_q.size(), 0);
      chk("frames_total", n_frames, 6);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

endmodule
